logic_gate_pipe: RTL and testbench

//  Parametrised successor to the single-bit 2-input gate.
//  - WIDTH-bit bitwise logic unit; eight runtime-selectable gate ops.
//  - Two-stage valid/ready pipeline with full-throughput backpressure.
//  - Sits between a producer and consumer stream as a registered gate stage.

---
 rtl/logic_gate_pipe.sv | 106 ++++++++++
 tb/tb_logic_gate_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready bitwise logic pipe: S1 registers operands, S2 registers the gate result.
// Define LOGIC_GATE_PIPE_POPCNT_EN to add out_ones, the population count of y registered with it.
module logic_gate_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic [2:0]                     op,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               y,
`ifdef LOGIC_GATE_PIPE_POPCNT_EN
    output logic [$clog2(WIDTH+1)-1:0]     out_ones,
`endif
    output logic [2:0]                     out_op
);

    localparam int unsigned OnesW = $clog2(WIDTH + 1);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [2:0]       s1_op_q;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, gate_d;
    logic [2:0]       op_q;
    logic             s1_adv, s2_adv;
    logic             s1_load, s2_load;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign s1_load    = s1_adv && in_valid;
    assign s2_load    = s2_adv && s1_valid_q;
    assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

    always_comb begin
        gate_d = '0;
        unique case (s1_op_q)
            3'b000:  gate_d = s1_a_q & s1_b_q;
            3'b001:  gate_d = s1_a_q | s1_b_q;
            3'b010:  gate_d = s1_a_q ^ s1_b_q;
            3'b011:  gate_d = ~(s1_a_q & s1_b_q);
            3'b100:  gate_d = ~(s1_a_q | s1_b_q);
            3'b101:  gate_d = ~(s1_a_q ^ s1_b_q);
            3'b110:  gate_d = s1_a_q & ~s1_b_q;
            default: gate_d = s1_a_q;
        endcase
    end

    // Operand registers are never observed while s1_valid_q is low, so they skip reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            op_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                y_q  <= gate_d;
                op_q <= s1_op_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && s1_load) begin
            s1_a_q  <= a;
            s1_b_q  <= b;
            s1_op_q <= op;
        end
    end

`ifdef LOGIC_GATE_PIPE_POPCNT_EN
    logic [OnesW-1:0] ones_d, ones_q;

    always_comb begin
        ones_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_d = ones_d + OnesW'(gate_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else if (s2_load) begin
            ones_q <= ones_d;
        end
    end

    assign out_ones = ones_q;
`endif

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign out_op    = op_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: directed scenarios plus a randomized scoreboard run.
// Define LOGIC_GATE_PIPE_POPCNT_EN on both RTL and bench to cover out_ones.
module tb_logic_gate_pipe;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic [2:0]       out_op;
`ifdef LOGIC_GATE_PIPE_POPCNT_EN
    logic [3:0]       out_ones;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
`ifdef LOGIC_GATE_PIPE_POPCNT_EN
        .out_ones  (out_ones),
`endif
        .out_op    (out_op)
    );

    // Gate truth table written from the op list, independent of the RTL.
    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] ga, input logic [WIDTH-1:0] gb,
                                                input logic [2:0] gop);
        case (gop)
            3'd0:    return ga & gb;
            3'd1:    return ga | gb;
            3'd2:    return ga ^ gb;
            3'd3:    return ~(ga & gb);
            3'd4:    return ~(ga | gb);
            3'd5:    return ~(ga ^ gb);
            3'd6:    return ga & ~gb;
            default: return ga;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                         input logic [2:0] dop, input logic ordy);
        in_valid  = iv;
        a         = da;
        b         = db;
        op        = dop;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 3'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Put two items in flight, stalled, then reset mid-stall with input still offered.
        drive(1'b1, 8'hAA, 8'h55, 3'd2, 1'b0);
        tick();
        drive(1'b1, 8'h0F, 8'h33, 3'd1, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 8'h12, 8'h34, 3'd0, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || out_op !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid: out_valid=%b y=%h out_op=%0d, want 0 00 0", out_valid, y, out_op);
        end
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || out_op !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: out_valid=%b y=%h out_op=%0d in_ready=%b, want 0 00 0 1",
                     out_valid, y, out_op, in_ready);
        end
`ifdef LOGIC_GATE_PIPE_POPCNT_EN
        checks++;
        if (out_ones !== 4'd0) begin
            failures++;
            $display("FAIL reset_ones: out_ones=%0d want 0", out_ones);
        end
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_discard: cycle %0d out_valid=%b want 0", c, out_valid);
            end
        end
        tick();
    endtask

    task automatic test_all_ops();
        logic [WIDTH-1:0] exp_y [8];
        exp_y = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(1'b1, 8'hF0, 8'hCC, 3'(c), 1'b1);
            else       drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                checks++;
                if (out_valid !== 1'b1 || y !== exp_y[c-2] || out_op !== 3'(c - 2)) begin
                    failures++;
                    $display("FAIL all_ops: cycle %0d out_valid=%b y=%h op=%0d, want 1 %h %0d",
                             c, out_valid, y, out_op, exp_y[c-2], c - 2);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL all_ops_idle: cycle %0d out_valid=%b want 0", c, out_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] got_y [$];
        logic [2:0]       got_op [$];
        do_reset();
        drive(1'b1, 8'hAA, 8'h55, 3'd2, 1'b0);
        tick();
        drive(1'b1, 8'h0F, 8'h33, 3'd0, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'h12, 8'h34, 3'd1, 1'b0);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || y !== 8'hFF || out_op !== 3'd2 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d out_valid=%b y=%h op=%0d in_ready=%b, want 1 ff 2 0",
                         c, out_valid, y, out_op, in_ready);
            end
            tick();
        end
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_y.push_back(y);
                got_op.push_back(out_op);
            end
            tick();
        end
        checks++;
        if (got_y.size() != 2) begin
            failures++;
            $display("FAIL stall_count: delivered %0d want 2", got_y.size());
        end else begin
            checks++;
            if (got_y[0] !== 8'hFF || got_op[0] !== 3'd2 || got_y[1] !== 8'h03 || got_op[1] !== 3'd0) begin
                failures++;
                $display("FAIL stall_order: got %h/%0d %h/%0d want ff/2 03/0",
                         got_y[0], got_op[0], got_y[1], got_op[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got_y [$];
        do_reset();
        drive(1'b1, 8'h11, 8'h00, 3'd7, 1'b0);
        tick();
        drive(1'b1, 8'h22, 8'h00, 3'd7, 1'b0);
        tick();
        // Full pipe: one out and one in on the same edge.
        drive(1'b1, 8'h33, 8'h00, 3'd7, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || y !== 8'h11) begin
            failures++;
            $display("FAIL b2b_both: in_ready=%b out_valid=%b y=%h want 1 1 11", in_ready, out_valid, y);
        end
        tick();
        drive(1'b0, '0, '0, 3'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h22 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_occupancy: out_valid=%b y=%h in_ready=%b want 1 22 0", out_valid, y, in_ready);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) got_y.push_back(y);
            tick();
        end
        checks++;
        if (got_y.size() != 2 || got_y[0] !== 8'h22 || got_y[1] !== 8'h33) begin
            failures++;
            $display("FAIL b2b_drain: delivered %0d items, want 22 then 33", got_y.size());
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q_y [$];
        logic [2:0]       q_op [$];
        logic             prev_stall;
        logic [WIDTH-1:0] prev_y;
        logic [2:0]       prev_op;
        logic [WIDTH-1:0] ey;
        logic [2:0]       eop;
        int               err;
        do_reset();
        prev_stall = 1'b0;
        prev_y     = '0;
        prev_op    = '0;
        err        = 0;
        for (int c = 0; c < 10000 + 20; c++) begin
            if (c < 10000) begin
                drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
                      1'($urandom_range(0, 2) != 0));
            end else begin
                drive(1'b0, '0, '0, 3'd0, 1'b1);
            end
            @(negedge clk);
            checks++;
            if (in_ready !== (q_y.size() < 2 || out_ready)) begin
                failures++;
                err++;
                if (err < 10) $display("FAIL rnd_in_ready: cycle %0d got %b occupancy %0d out_ready %b",
                                       c, in_ready, q_y.size(), out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || y !== prev_y || out_op !== prev_op) begin
                    failures++;
                    err++;
                    if (err < 10) $display("FAIL rnd_hold: cycle %0d got %b %h/%0d want 1 %h/%0d",
                                           c, out_valid, y, out_op, prev_y, prev_op);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q_y.size() == 0) begin
                    failures++;
                    err++;
                    if (err < 10) $display("FAIL rnd_spurious: cycle %0d got y=%h want no output", c, y);
                end else if (out_ready) begin
                    ey  = q_y.pop_front();
                    eop = q_op.pop_front();
                    if (y !== ey || out_op !== eop) begin
                        failures++;
                        err++;
                        if (err < 10) $display("FAIL rnd_data: cycle %0d got %h/%0d want %h/%0d",
                                               c, y, out_op, ey, eop);
                    end
`ifdef LOGIC_GATE_PIPE_POPCNT_EN
                    checks++;
                    if (out_ones !== 4'($countones(ey))) begin
                        failures++;
                        err++;
                        if (err < 10) $display("FAIL rnd_ones: cycle %0d got %0d want %0d",
                                               c, out_ones, $countones(ey));
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                q_y.push_back(golden(a, b, op));
                q_op.push_back(op);
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_op    = out_op;
            tick();
        end
        checks++;
        if (q_y.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain: %0d items never delivered, want 0", q_y.size());
        end
    endtask

`ifdef LOGIC_GATE_PIPE_POPCNT_EN
    task automatic test_popcnt();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      drive(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1);
            else if (c == 1) drive(1'b1, 8'hFF, 8'h0F, 3'd7, 1'b1);
            else             drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (out_valid !== 1'b1 || y !== 8'h0F || out_ones !== 4'd4) begin
                    failures++;
                    $display("FAIL popcnt_and: got %b %h ones=%0d want 1 0f 4", out_valid, y, out_ones);
                end
            end else if (c == 3) begin
                checks++;
                if (out_valid !== 1'b1 || y !== 8'hFF || out_ones !== 4'd8) begin
                    failures++;
                    $display("FAIL popcnt_pass: got %b %h ones=%0d want 1 ff 8", out_valid, y, out_ones);
                end
            end
            tick();
        end
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_all_ops();
        test_stall();
        test_back_to_back();
`ifdef LOGIC_GATE_PIPE_POPCNT_EN
        test_popcnt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
